// File: rtl/pulse_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_cnt_pkg
// Description : Shared edge-mode encodings and qualified-event decode for the
//               multi-channel pulse counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_cnt_pkg;

    // Edge-mode encodings presented on i_edge_mode
    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_HIGH = 2'b11;

    // Decode one channel's qualified event from the synchronised level (s2)
    // and its one-cycle history (s3). Both-edge mode can only ever produce a
    // single event per cycle, since rise and fall are mutually exclusive.
    function automatic logic qual_event(
        input logic [1:0] mode,
        input logic       s2,
        input logic       s3
    );
        logic w_evt;
        w_evt = 1'b0;
        case (mode)
            EDGE_RISE: w_evt = s2 & ~s3;
            EDGE_FALL: w_evt = ~s2 & s3;
            EDGE_BOTH: w_evt = s2 ^ s3;
            default:   w_evt = s2;
        endcase
        return w_evt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_cnt_ch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_cnt_ch
// Description : One pulse-counter channel: 2-flop synchroniser, history flop,
//               event decode, live counter and sticky overflow flag.
//               Build option PULSE_CNT_SAT_EN: counter saturates at its
//               maximum instead of wrapping to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_cnt_ch
    import pulse_cnt_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pulse,
    input  logic             i_en,
    input  logic [1:0]       i_edge_mode,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             w_evt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    // Synchronise the asynchronous input and keep one cycle of history.
    // History resets low, so an input held high through reset reads as a rise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_pulse;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Qualified event for the selected mode; enable gating happens at the counter
    always_comb begin
        w_evt = qual_event(i_edge_mode, r_s2, r_s3);
    end

    // Live counter and sticky overflow: reset > clear > increment
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_en && w_evt) begin
            if (r_cnt == c_cnt_max) begin
`ifdef PULSE_CNT_SAT_EN
                r_cnt <= c_cnt_max;
`else
                r_cnt <= '0;
`endif
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/pulse_cnt_multi.sv
`default_nettype none
// ============================================================================
// Module      : pulse_cnt_multi
// Description : CH_NUM-channel pulse/high-time counter with sticky overflow,
//               synchronous clear, atomic snapshot into a shadow bank and a
//               single indexed read port onto the shadow bank.
//               Build option PULSE_CNT_SAT_EN: per-channel counters saturate
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_cnt_multi
    import pulse_cnt_pkg::*;
#(
    parameter int CH_NUM = 16,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CH_NUM-1:0] i_pulse,
    input  logic              i_en,
    input  logic [1:0]        i_edge_mode,
    input  logic              i_clr,
    input  logic              i_snap,
    input  logic              i_rd_req,
    input  logic [CH_W-1:0]   i_rd_ch,
    output logic              o_rd_vld,
    output logic [CNT_W-1:0]  o_rd_data,
    output logic [CH_NUM-1:0] o_ovf
);

    logic [CNT_W-1:0] w_live   [CH_NUM];
    logic [CNT_W-1:0] r_shadow [CH_NUM];
    logic [CNT_W-1:0] w_rd_sel;
    logic             r_rd_vld;
    logic [CNT_W-1:0] r_rd_data;

    generate
        for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
            pulse_cnt_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_pulse     (i_pulse[g]),
                .i_en        (i_en),
                .i_edge_mode (i_edge_mode),
                .i_clr       (i_clr),
                .o_cnt       (w_live[g]),
                .o_ovf       (o_ovf[g])
            );
        end
    endgenerate

    // Shadow bank captures the pre-update live values, so snap+clear in the
    // same cycle is an atomic read-and-clear. Clear never touches the shadow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (i_snap) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_shadow[i] <= w_live[i];
            end
        end
    end

    // Read mux over the shadow bank; an index past the last channel selects 0
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (i_rd_ch == CH_W'(i)) begin
                w_rd_sel = r_shadow[i];
            end
        end
    end

    // Registered read port: valid one cycle after the request, data held otherwise.
    // The mux sees the shadow before any same-cycle snapshot lands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld <= i_rd_req;
            if (i_rd_req) begin
                r_rd_data <= w_rd_sel;
            end
        end
    end

    assign o_rd_vld  = r_rd_vld;
    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_pulse_cnt_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_cnt_multi
// Description : Directed self-checking bench for pulse_cnt_multi. A 16x16
//               instance covers counting, gating, snapshot and reads; a
//               12-channel, 4-bit instance covers overflow and out-of-range
//               reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_cnt_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [15:0] b_pulse;
    logic        b_en;
    logic [1:0]  b_mode;
    logic        b_clr;
    logic        b_snap;
    logic        b_rd_req;
    logic [3:0]  b_rd_ch;
    logic        b_rd_vld;
    logic [15:0] b_rd_data;
    logic [15:0] b_ovf;

    logic [11:0] s_pulse;
    logic        s_en;
    logic [1:0]  s_mode;
    logic        s_clr;
    logic        s_snap;
    logic        s_rd_req;
    logic [3:0]  s_rd_ch;
    logic        s_rd_vld;
    logic [3:0]  s_rd_data;
    logic [11:0] s_ovf;

    int errors = 0;
    int checks = 0;
    int prev_shadow [16];

    pulse_cnt_multi #(.CH_NUM(16), .CNT_W(16)) u_big (
        .i_clk(clk), .i_rst(rst), .i_pulse(b_pulse), .i_en(b_en),
        .i_edge_mode(b_mode), .i_clr(b_clr), .i_snap(b_snap),
        .i_rd_req(b_rd_req), .i_rd_ch(b_rd_ch), .o_rd_vld(b_rd_vld),
        .o_rd_data(b_rd_data), .o_ovf(b_ovf)
    );

    pulse_cnt_multi #(.CH_NUM(12), .CNT_W(4)) u_small (
        .i_clk(clk), .i_rst(rst), .i_pulse(s_pulse), .i_en(s_en),
        .i_edge_mode(s_mode), .i_clr(s_clr), .i_snap(s_snap),
        .i_rd_req(s_rd_req), .i_rd_ch(s_rd_ch), .o_rd_vld(s_rd_vld),
        .o_rd_data(s_rd_data), .o_ovf(s_ovf)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic b_snap_pulse();
        b_snap = 1'b1; tick(1); b_snap = 1'b0;
    endtask

    task automatic b_clr_pulse();
        b_clr = 1'b1; tick(1); b_clr = 1'b0;
    endtask

    task automatic s_snap_pulse();
        s_snap = 1'b1; tick(1); s_snap = 1'b0;
    endtask

    task automatic s_clr_pulse();
        s_clr = 1'b1; tick(1); s_clr = 1'b0;
    endtask

    task automatic b_read(input logic [3:0] ch, output logic v, output logic [15:0] d);
        b_rd_req = 1'b1; b_rd_ch = ch;
        tick(1);
        v = b_rd_vld; d = b_rd_data;
        b_rd_req = 1'b0;
    endtask

    task automatic s_read(input logic [3:0] ch, output logic v, output logic [3:0] d);
        s_rd_req = 1'b1; s_rd_ch = ch;
        tick(1);
        v = s_rd_vld; d = s_rd_data;
        s_rd_req = 1'b0;
    endtask

    task automatic test_reset();
        logic v; logic [15:0] d;
        rst = 1'b1; b_pulse = 16'hFFFF; s_pulse = 12'hFFF;
        tick(5);
        checks++;
        if (b_ovf !== 16'h0 || b_rd_vld !== 1'b0 || b_rd_data !== 16'h0)
            $display("FAIL reset_in: ovf=%h vld=%b data=%h expected 0/0/0", b_ovf, b_rd_vld, b_rd_data);
        checks++;
        if (s_ovf !== 12'h0 || s_rd_vld !== 1'b0)
            $display("FAIL reset_in_small: ovf=%h vld=%b expected 0/0", s_ovf, s_rd_vld);
        if (b_ovf !== 16'h0 || b_rd_vld !== 1'b0 || b_rd_data !== 16'h0) errors++;
        if (s_ovf !== 12'h0 || s_rd_vld !== 1'b0) errors++;
        rst = 1'b0;
        tick(100);
        b_snap_pulse();
        for (int c = 0; c < 16; c++) begin
            b_read(4'(c), v, d);
            checks++;
            if (v !== 1'b1 || d !== 16'h0) begin
                errors++;
                $display("FAIL reset_read ch%0d: vld=%b data=%0d expected vld=1 data=0", c, v, d);
            end
        end
        checks++;
        if (b_ovf !== 16'h0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%h expected 0", b_ovf);
        end
    endtask

    task automatic test_count(input logic [1:0] mode);
        int exp_cnt [16];
        logic [15:0] pat;
        logic v; logic [15:0] d;
        b_en = 1'b0; b_pulse = 16'h0; tick(5);
        b_clr_pulse();
        b_mode = mode; b_en = 1'b1; tick(2);
        for (int c = 0; c < 16; c++) exp_cnt[c] = 0;
        for (int p = 0; p < 50; p++) begin
            pat = 16'($urandom);
            b_pulse = pat; tick(30);
            b_pulse = 16'h0; tick(50);
            for (int c = 0; c < 16; c++)
                if (pat[c]) exp_cnt[c] += (mode == 2'b10) ? 2 : 1;
        end
        b_snap_pulse();
        for (int c = 0; c < 16; c++) begin
            b_read(4'(c), v, d);
            checks++;
            if (v !== 1'b1 || d !== 16'(exp_cnt[c])) begin
                errors++;
                $display("FAIL count_m%0d ch%0d: vld=%b count=%0d expected %0d", mode, c, v, d, exp_cnt[c]);
            end
            prev_shadow[c] = exp_cnt[c];
        end
        checks++;
        if (b_ovf !== 16'h0) begin
            errors++;
            $display("FAIL count_ovf_m%0d: ovf=%h expected 0", mode, b_ovf);
        end
    endtask

    task automatic test_enable_gating();
        logic v; logic [15:0] d;
        b_en = 1'b0;
        for (int p = 0; p < 15; p++) begin
            b_pulse = 16'($urandom); tick(10);
            b_pulse = 16'h0; tick(10);
        end
        tick(5);
        b_snap_pulse();
        for (int c = 0; c < 16; c++) begin
            b_read(4'(c), v, d);
            checks++;
            if (v !== 1'b1 || d !== 16'(prev_shadow[c])) begin
                errors++;
                $display("FAIL gating ch%0d: count=%0d expected %0d", c, d, prev_shadow[c]);
            end
        end
    endtask

    task automatic test_snap_clr_collision();
        logic v; logic [15:0] d;
        b_en = 1'b0; b_pulse = 16'h0; b_mode = 2'b00; tick(3);
        b_clr_pulse(); b_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_pulse[0] = 1'b1; tick(2); b_pulse[0] = 1'b0; tick(2);
        end
        tick(4);
        b_snap_pulse();
        for (int i = 0; i < 4; i++) begin
            b_pulse[0] = 1'b1; tick(2); b_pulse[0] = 1'b0; tick(2);
        end
        tick(4);
        // Rising edge reaches the counter on the same edge as snap+clr+read
        b_pulse[0] = 1'b1; tick(2);
        b_snap = 1'b1; b_clr = 1'b1; b_rd_req = 1'b1; b_rd_ch = 4'd0;
        tick(1);
        checks++;
        if (b_rd_vld !== 1'b1 || b_rd_data !== 16'd3) begin
            errors++;
            $display("FAIL collide_read: vld=%b data=%0d expected vld=1 data=3", b_rd_vld, b_rd_data);
        end
        b_snap = 1'b0; b_clr = 1'b0; b_rd_req = 1'b0;
        b_pulse[0] = 1'b0; tick(4);
        b_read(4'd0, v, d);
        checks++;
        if (d !== 16'd7) begin
            errors++;
            $display("FAIL collide_shadow: shadow0=%0d expected 7", d);
        end
        b_snap_pulse();
        b_read(4'd0, v, d);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL collide_live: live0=%0d expected 0", d);
        end
    endtask

    task automatic test_high_time();
        logic v; logic [15:0] d;
        b_en = 1'b0; b_pulse = 16'h0; b_mode = 2'b11; tick(3);
        b_clr_pulse(); b_en = 1'b1;
        b_pulse[5] = 1'b1; tick(20);
        b_pulse[5] = 1'b0; tick(5);
        b_snap_pulse();
        b_read(4'd5, v, d);
        checks++;
        if (v !== 1'b1 || d !== 16'd20) begin
            errors++;
            $display("FAIL high_time ch5: vld=%b count=%0d expected 20", v, d);
        end
        b_read(4'd4, v, d);
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("FAIL high_time ch4: count=%0d expected 0", d);
        end
    endtask

    task automatic test_back_to_back();
        b_rd_req = 1'b1; b_rd_ch = 4'd5; tick(1);
        checks++;
        if (b_rd_vld !== 1'b1 || b_rd_data !== 16'd20) begin
            errors++;
            $display("FAIL b2b_0: vld=%b data=%0d expected 1/20", b_rd_vld, b_rd_data);
        end
        b_rd_ch = 4'd4; tick(1);
        checks++;
        if (b_rd_vld !== 1'b1 || b_rd_data !== 16'd0) begin
            errors++;
            $display("FAIL b2b_1: vld=%b data=%0d expected 1/0", b_rd_vld, b_rd_data);
        end
        b_rd_ch = 4'd5; tick(1);
        checks++;
        if (b_rd_vld !== 1'b1 || b_rd_data !== 16'd20) begin
            errors++;
            $display("FAIL b2b_2: vld=%b data=%0d expected 1/20", b_rd_vld, b_rd_data);
        end
        b_rd_req = 1'b0; tick(1);
        checks++;
        if (b_rd_vld !== 1'b0 || b_rd_data !== 16'd20) begin
            errors++;
            $display("FAIL b2b_hold: vld=%b data=%0d expected 0/20", b_rd_vld, b_rd_data);
        end
    endtask

    task automatic test_overflow();
        logic v; logic [3:0] d;
        logic [3:0] exp_wrap;
`ifdef PULSE_CNT_SAT_EN
        exp_wrap = 4'd15;
`else
        exp_wrap = 4'd1;
`endif
        s_en = 1'b0; s_pulse = 12'h0; s_mode = 2'b00; tick(3);
        s_clr_pulse(); s_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            s_pulse[3] = 1'b1; tick(2); s_pulse[3] = 1'b0; tick(2);
        end
        tick(4);
        s_snap_pulse();
        s_read(4'd3, v, d);
        checks++;
        if (d !== 4'd15 || s_ovf !== 12'h0) begin
            errors++;
            $display("FAIL ovf_at_max: count=%0d ovf=%h expected 15/000", d, s_ovf);
        end
        for (int i = 0; i < 2; i++) begin
            s_pulse[3] = 1'b1; tick(2); s_pulse[3] = 1'b0; tick(2);
        end
        tick(4);
        s_snap_pulse();
        s_read(4'd3, v, d);
        checks++;
        if (d !== exp_wrap || s_ovf !== 12'h008) begin
            errors++;
            $display("FAIL ovf_past_max: count=%0d ovf=%h expected %0d/008", d, s_ovf, exp_wrap);
        end
        s_read(4'd2, v, d);
        checks++;
        if (d !== 4'd0) begin
            errors++;
            $display("FAIL ovf_neighbour ch2: count=%0d expected 0", d);
        end
        s_clr_pulse();
        s_snap_pulse();
        s_read(4'd3, v, d);
        checks++;
        if (d !== 4'd0 || s_ovf !== 12'h0) begin
            errors++;
            $display("FAIL ovf_clear: count=%0d ovf=%h expected 0/000", d, s_ovf);
        end
    endtask

    task automatic test_out_of_range();
        logic v; logic [3:0] d;
        s_en = 1'b0; s_pulse = 12'h0; s_mode = 2'b11; tick(3);
        s_clr_pulse(); s_en = 1'b1;
        s_pulse = 12'hFFF; tick(5);
        s_pulse = 12'h0; tick(4);
        s_snap_pulse();
        s_read(4'd13, v, d);
        checks++;
        if (v !== 1'b1 || d !== 4'd0) begin
            errors++;
            $display("FAIL oob_read ch13: vld=%b data=%0d expected 1/0", v, d);
        end
        s_read(4'd11, v, d);
        checks++;
        if (v !== 1'b1 || d !== 4'd5) begin
            errors++;
            $display("FAIL last_ch read ch11: vld=%b data=%0d expected 1/5", v, d);
        end
        tick(1);
        checks++;
        if (s_rd_vld !== 1'b0 || s_rd_data !== 4'd5) begin
            errors++;
            $display("FAIL rd_hold: vld=%b data=%0d expected 0/5", s_rd_vld, s_rd_data);
        end
    endtask

    task automatic test_reset_mid();
        logic v; logic [15:0] d;
        b_mode = 2'b11; b_en = 1'b1; b_pulse = 16'hFFFF; tick(10);
        rst = 1'b1; b_rd_req = 1'b1; b_rd_ch = 4'd5;
        tick(1);
        checks++;
        if (b_rd_vld !== 1'b0 || b_rd_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_rd: vld=%b data=%0d expected 0/0", b_rd_vld, b_rd_data);
        end
        rst = 1'b0; b_rd_req = 1'b0; b_pulse = 16'h0; b_en = 1'b0;
        tick(5);
        b_snap_pulse();
        b_read(4'd5, v, d);
        checks++;
        if (d !== 16'd0 || b_ovf !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_cnt: count=%0d ovf=%h expected 0/0", d, b_ovf);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        b_pulse = '0; b_en = 1'b0; b_mode = 2'b00; b_clr = 1'b0; b_snap = 1'b0;
        b_rd_req = 1'b0; b_rd_ch = '0;
        s_pulse = '0; s_en = 1'b0; s_mode = 2'b00; s_clr = 1'b0; s_snap = 1'b0;
        s_rd_req = 1'b0; s_rd_ch = '0;
        tick(1);
        test_reset();
        test_count(2'b00);
        test_count(2'b01);
        test_count(2'b10);
        test_enable_gating();
        test_snap_clr_collision();
        test_high_time();
        test_back_to_back();
        test_overflow();
        test_out_of_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
